// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF packet arbiter: channel ids, FSM states
// and the packet-length code decode.
package mcdf_pkg;

  localparam logic [1:0] CH0     = 2'b00;
  localparam logic [1:0] CH1     = 2'b01;
  localparam logic [1:0] CH2     = 2'b10;
  localparam logic [1:0] CH_NONE = 2'b11;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_e;

  // Codes 3..7 all saturate at the largest packet size.
  function automatic logic [5:0] pkglen_beats(input logic [2:0] code);
    logic [5:0] beats;
    case (code)
      3'd0:    beats = 6'd4;
      3'd1:    beats = 6'd8;
      3'd2:    beats = 6'd16;
      default: beats = 6'd32;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mcdf_pkt_arbiter_if.sv
// Bundle of channel-side and formatter-side signals around the packet arbiter.
// The arbiter uses the slave modport; the surrounding channels/formatter use master.
interface mcdf_pkt_arbiter_if #(
  parameter int DW = 32
);
  logic [1:0]    slv0_prio_i,   slv1_prio_i,   slv2_prio_i;
  logic [2:0]    slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i;
  logic [DW-1:0] slv0_data_i,   slv1_data_i,   slv2_data_i;
  logic          slv0_req_i,    slv1_req_i,    slv2_req_i;
  logic          slv0_val_i,    slv1_val_i,    slv2_val_i;
  logic          a2s0_ack_o,    a2s1_ack_o,    a2s2_ack_o;
  logic          f2a_id_req_i;
  logic          f2a_ack_i;
  logic          a2f_val_o;
  logic [1:0]    a2f_id_o;
  logic [DW-1:0] a2f_data_o;
  logic [2:0]    a2f_pkglen_sel_o;

  modport slave (
    input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
    input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    input  slv0_data_i, slv1_data_i, slv2_data_i,
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_val_i, slv1_val_i, slv2_val_i,
    output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    input  f2a_id_req_i, f2a_ack_i,
    output a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o
  );

  modport master (
    output slv0_prio_i, slv1_prio_i, slv2_prio_i,
    output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    output slv0_data_i, slv1_data_i, slv2_data_i,
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_val_i, slv1_val_i, slv2_val_i,
    input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    output f2a_id_req_i, f2a_ack_i,
    input  a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o
  );
endinterface

// File: rtl/mcdf_rr_prio_pick.sv
// Combinational winner selection: aged requesters first, otherwise lowest
// priority value, with round-robin tie-break starting after rr_ptr_i.
module mcdf_rr_prio_pick
  import mcdf_pkg::*;
(
  input  logic [2:0]      req_i,
  input  logic [2:0][1:0] prio_i,
  input  logic [1:0]      rr_ptr_i,
  input  logic [2:0]      aged_i,
  output logic [1:0]      winner_o
);

  logic [1:0] min_prio;
  logic [2:0] cand;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    min_prio = 2'd3;
    cand     = 3'b000;
    idx      = 2'd0;
    found    = 1'b0;
    winner_o = CH_NONE;

    for (int i = 0; i < 3; i++) begin
      if (req_i[i] && (prio_i[i] < min_prio)) begin
        min_prio = prio_i[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      cand[i] = req_i[i] && (prio_i[i] == min_prio);
    end
    // Any aged requester overrides priority entirely.
    if (|(req_i & aged_i)) begin
      cand = req_i & aged_i;
    end

    idx = (rr_ptr_i >= 2'd2) ? 2'd0 : rr_ptr_i + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && cand[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/mcdf_pkt_arbiter.sv
// Packet-level arbiter between the three MCDF channels and the formatter.
// Optional starvation aging is enabled by defining MCDF_ARB_AGING_EN.
module mcdf_pkt_arbiter
  import mcdf_pkg::*;
#(
  parameter int DW = 32
`ifdef MCDF_ARB_AGING_EN
  ,
  parameter int AGE_LIMIT = 4
`endif
) (
  input logic               clk_i,
  input logic               rst_i,
  mcdf_pkt_arbiter_if.slave bus
);

  arb_state_e      state_q, state_d;
  logic [1:0]      id_q, id_d;
  logic [2:0]      pkglen_q, pkglen_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      rr_q, rr_d;

  logic [2:0]      req;
  logic [2:0][1:0] prio;
  logic [2:0]      aged;
  logic [1:0]      winner;
  logic [2:0]      win_pkglen;
  logic            beat;
  logic            out_val;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_ack;

  assign req  = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign prio = {bus.slv2_prio_i, bus.slv1_prio_i, bus.slv0_prio_i};

  mcdf_rr_prio_pick u_pick (
    .req_i    (req),
    .prio_i   (prio),
    .rr_ptr_i (rr_q),
    .aged_i   (aged),
    .winner_o (winner)
  );

  always_comb begin
    win_pkglen = 3'b111;
    case (winner)
      CH0:     win_pkglen = bus.slv0_pkglen_i;
      CH1:     win_pkglen = bus.slv1_pkglen_i;
      CH2:     win_pkglen = bus.slv2_pkglen_i;
      default: win_pkglen = 3'b111;
    endcase
  end

  // Output path follows the registered grant; CH_NONE parks everything idle.
  always_comb begin
    out_val  = 1'b0;
    out_data = '1;
    out_ack  = 3'b000;
    case (id_q)
      CH0: begin
        out_val    = bus.slv0_val_i;
        out_data   = bus.slv0_data_i;
        out_ack[0] = bus.f2a_ack_i;
      end
      CH1: begin
        out_val    = bus.slv1_val_i;
        out_data   = bus.slv1_data_i;
        out_ack[1] = bus.f2a_ack_i;
      end
      CH2: begin
        out_val    = bus.slv2_val_i;
        out_data   = bus.slv2_data_i;
        out_ack[2] = bus.f2a_ack_i;
      end
      default: begin
        out_val  = 1'b0;
        out_data = '1;
        out_ack  = 3'b000;
      end
    endcase
  end

  assign bus.a2f_val_o        = out_val;
  assign bus.a2f_data_o       = out_data;
  assign bus.a2f_id_o         = id_q;
  assign bus.a2f_pkglen_sel_o = pkglen_q;
  assign bus.a2s0_ack_o       = out_ack[0];
  assign bus.a2s1_ack_o       = out_ack[1];
  assign bus.a2s2_ack_o       = out_ack[2];

  assign beat = out_val && bus.f2a_ack_i;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pkglen_d = pkglen_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (bus.f2a_id_req_i && (|req)) begin
          state_d  = XFER;
          id_d     = winner;
          pkglen_d = win_pkglen;
          len_d    = pkglen_beats(win_pkglen);
          cnt_d    = 6'd0;
        end
      end
      XFER: begin
        if (beat) begin
          if (cnt_q == (len_q - 6'd1)) begin
            state_d  = IDLE;
            id_d     = CH_NONE;
            pkglen_d = 3'b111;
            rr_d     = id_q;
            cnt_d    = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = CH_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= CH_NONE;
      pkglen_q <= 3'b111;
      len_q    <= 6'd0;
      cnt_q    <= 6'd0;
      rr_q     <= CH2;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pkglen_q <= pkglen_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
    end
  end

`ifdef MCDF_ARB_AGING_EN
  localparam logic [2:0] AGE_LIM3 = 3'(AGE_LIMIT);

  logic [2:0][2:0] age_q, age_d;
  logic            arb_win;
  logic [2:0]      win_oh;

  assign arb_win = (state_q == IDLE) && bus.f2a_id_req_i && (|req);
  assign win_oh  = 3'b001 << winner;

  // Losing requesters age (saturating); the winner starts over.
  always_comb begin
    age_d = age_q;
    aged  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      aged[i] = (age_q[i] >= AGE_LIM3);
      if (arb_win) begin
        if (win_oh[i]) begin
          age_d[i] = 3'd0;
        end else if (req[i] && (age_q[i] != 3'd7)) begin
          age_d[i] = age_q[i] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign aged = 3'b000;
`endif

endmodule
